// File: rtl/proc_pkg.sv
// ============================================================================
// Module   : proc_pkg
// Brief    : Shared widths and result record for the writeback slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int DATA_W  = 16;
    localparam int REG_AW  = 4;
    localparam int NUM_REG = 2 ** REG_AW;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } result_t;

endpackage

`default_nettype wire

// File: rtl/wb_skid_buffer.sv
// ============================================================================
// Module   : wb_skid_buffer
// Brief    : One-entry holder for an ALU result displaced by a load result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_skid_buffer
    import proc_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    load,
    input  logic    unload,
    input  result_t din,
    output logic    valid,
    output result_t dout,
    output logic    ready
);

    logic    r_valid;
    result_t r_entry;

    // Load only happens while empty, so it never races an unload.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_entry <= din;
        end else if (unload) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign dout  = r_entry;
    assign ready = ~r_valid;

endmodule

`default_nettype wire

// File: rtl/reg_writeback_unit.sv
// ============================================================================
// Module   : reg_writeback_unit
// Brief    : Merges ALU/load results into one register-file write per cycle
//            and tracks pending writes to stall decode on RAW/WAW hazards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_writeback_unit
    import proc_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [REG_AW-1:0]  issue_rs1,
    input  logic [REG_AW-1:0]  issue_rs2,
    input  logic [REG_AW-1:0]  issue_rd,
    input  logic               issue_wr,
    output logic               stall,
    input  logic               alu_valid,
    input  logic [REG_AW-1:0]  alu_rd,
    input  logic [DATA_W-1:0]  alu_data,
    output logic               alu_ready,
    input  logic               mem_valid,
    input  logic [REG_AW-1:0]  mem_rd,
    input  logic [DATA_W-1:0]  mem_data,
    output logic               wb_write,
    output logic [REG_AW-1:0]  wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    output logic [NUM_REG-1:0] busy,
    output logic               err
);

    logic [NUM_REG-1:0] r_busy;
    logic               r_wb_write;
    logic [REG_AW-1:0]  r_wb_rd;
    logic [DATA_W-1:0]  r_wb_data;
    logic               r_err;

    logic               w_skid_valid;
    logic               w_skid_ready;
    logic               w_skid_load;
    logic               w_skid_unload;
    result_t            w_skid_dout;
    result_t            w_alu_res;
    result_t            w_sel;
    logic               w_sel_valid;
    logic               w_sel_write;
    logic               w_alu_take;
    logic               w_issue_accept;
    logic [NUM_REG-1:0] w_set_mask;
    logic [NUM_REG-1:0] w_clr_mask;

    assign w_alu_res  = '{rd: alu_rd, data: alu_data};
    assign w_alu_take = alu_valid & w_skid_ready;

    wb_skid_buffer u_skid (
        .clock  (clock),
        .reset  (reset),
        .load   (w_skid_load),
        .unload (w_skid_unload),
        .din    (w_alu_res),
        .valid  (w_skid_valid),
        .dout   (w_skid_dout),
        .ready  (w_skid_ready)
    );

    // Priority: load result, then the older skid entry, then a live ALU result.
    always_comb begin
        w_sel_valid   = 1'b0;
        w_sel         = '0;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        if (mem_valid) begin
            w_sel_valid = 1'b1;
            w_sel       = '{rd: mem_rd, data: mem_data};
            w_skid_load = w_alu_take;
        end else if (w_skid_valid) begin
            w_sel_valid   = 1'b1;
            w_sel         = w_skid_dout;
            w_skid_unload = 1'b1;
        end else if (w_alu_take) begin
            w_sel_valid = 1'b1;
            w_sel       = w_alu_res;
        end
    end

    assign w_sel_write = w_sel_valid & (w_sel.rd != REG_ZERO);

    assign stall = issue_valid &
                   ((r_busy[issue_rs1] & (issue_rs1 != REG_ZERO)) |
                    (r_busy[issue_rs2] & (issue_rs2 != REG_ZERO)) |
                    (issue_wr & r_busy[issue_rd] & (issue_rd != REG_ZERO)));

    assign w_issue_accept = issue_valid & ~stall & issue_wr & (issue_rd != REG_ZERO);

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        w_set_mask[issue_rd] = w_issue_accept;
        w_clr_mask[w_sel.rd] = w_sel_write;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy     <= '0;
            r_wb_write <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy     <= (r_busy & ~w_clr_mask) | w_set_mask;
            r_wb_write <= w_sel_write;
            if (w_sel_write) begin
                r_wb_rd   <= w_sel.rd;
                r_wb_data <= w_sel.data;
            end
            // A write to a register nobody was waiting on is a protocol slip.
            if (w_sel_write && !r_busy[w_sel.rd]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign alu_ready = w_skid_ready;
    assign wb_write  = r_wb_write;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
// ============================================================================
// Module   : tb_reg_writeback_unit
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_writeback_unit;
    import proc_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               issue_valid, issue_wr;
    logic [REG_AW-1:0]  issue_rs1, issue_rs2, issue_rd;
    logic               stall;
    logic               alu_valid;
    logic [REG_AW-1:0]  alu_rd;
    logic [DATA_W-1:0]  alu_data;
    logic               alu_ready;
    logic               mem_valid;
    logic [REG_AW-1:0]  mem_rd;
    logic [DATA_W-1:0]  mem_data;
    logic               wb_write;
    logic [REG_AW-1:0]  wb_rd;
    logic [DATA_W-1:0]  wb_data;
    logic [NUM_REG-1:0] busy;
    logic               err;

    int vectors = 0;
    int miscompares = 0;

    reg_writeback_unit dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_wr(issue_wr), .stall(stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        issue_valid = 0; issue_wr = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic issue_one(input logic [REG_AW-1:0] rd);
        issue_valid = 1; issue_wr = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = rd;
        tick();
        issue_valid = 0; issue_wr = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({wb_write, wb_rd, wb_data, busy, err, alu_ready, stall} !==
            {1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: wr=%b rd=%h data=%h busy=%h err=%b rdy=%b stall=%b expected all zero, rdy=1",
                     wb_write, wb_rd, wb_data, busy, err, alu_ready, stall);
        end
    endtask

    task automatic test_basic_write();
        issue_one(4'd3);
        vectors++;
        if (busy !== 16'h0008) begin
            miscompares++;
            $display("FAIL basic_busy_set: busy=%h expected 0008", busy);
        end
        alu_valid = 1; alu_rd = 4'd3; alu_data = 16'h1234;
        tick();
        alu_valid = 0;
        vectors++;
        if ({wb_write, wb_rd, wb_data, busy} !== {1'b1, 4'd3, 16'h1234, 16'h0000}) begin
            miscompares++;
            $display("FAIL basic_write: wr=%b rd=%0d data=%h busy=%h expected 1 3 1234 0000",
                     wb_write, wb_rd, wb_data, busy);
        end
        tick();
        vectors++;
        if (wb_write !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_write_drop: wb_write=%b expected 0", wb_write);
        end
    endtask

    task automatic test_stall();
        issue_one(4'd5);
        issue_valid = 1; issue_wr = 0; issue_rs1 = 4'd5; issue_rs2 = 0; issue_rd = 0;
        alu_valid = 1; alu_rd = 4'd5; alu_data = 16'hBEEF;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_raw: stall=%b expected 1", stall);
        end
        tick();
        alu_valid = 0;
        #1;
        vectors++;
        if ({stall, wb_write, wb_rd, busy} !== {1'b0, 1'b1, 4'd5, 16'h0}) begin
            miscompares++;
            $display("FAIL stall_release: stall=%b wr=%b rd=%0d busy=%h expected 0 1 5 0000",
                     stall, wb_write, wb_rd, busy);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_collision();
        issue_one(4'd4);
        issue_one(4'd6);
        mem_valid = 1; mem_rd = 4'd4; mem_data = 16'hAAAA;
        alu_valid = 1; alu_rd = 4'd6; alu_data = 16'h5555;
        #1;
        vectors++;
        if (alu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_ready_before: alu_ready=%b expected 1", alu_ready);
        end
        tick();
        idle_inputs();
        vectors++;
        if ({wb_write, wb_rd, wb_data, alu_ready} !== {1'b1, 4'd4, 16'hAAAA, 1'b0}) begin
            miscompares++;
            $display("FAIL collide_mem_first: wr=%b rd=%0d data=%h rdy=%b expected 1 4 aaaa 0",
                     wb_write, wb_rd, wb_data, alu_ready);
        end
        tick();
        vectors++;
        if ({wb_write, wb_rd, wb_data, alu_ready, busy} !== {1'b1, 4'd6, 16'h5555, 1'b1, 16'h0}) begin
            miscompares++;
            $display("FAIL collide_alu_next: wr=%b rd=%0d data=%h rdy=%b busy=%h expected 1 6 5555 1 0000",
                     wb_write, wb_rd, wb_data, alu_ready, busy);
        end
        tick();
    endtask

    task automatic test_rd_zero();
        alu_valid = 1; alu_rd = 4'd0; alu_data = 16'hFFFF;
        tick();
        alu_valid = 0;
        vectors++;
        if ({wb_write, busy, err} !== {1'b0, 16'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_zero: wr=%b busy=%h err=%b expected 0 0000 0", wb_write, busy, err);
        end
    endtask

    task automatic test_err();
        alu_valid = 1; alu_rd = 4'd7; alu_data = 16'h0777;
        tick();
        alu_valid = 0;
        vectors++;
        if ({wb_write, wb_rd, wb_data, err} !== {1'b1, 4'd7, 16'h0777, 1'b1}) begin
            miscompares++;
            $display("FAIL err_set: wr=%b rd=%0d data=%h err=%b expected 1 7 0777 1",
                     wb_write, wb_rd, wb_data, err);
        end
        tick();
        tick();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b expected 1", err);
        end
    endtask

    task automatic test_async_reset();
        issue_one(4'd8);
        issue_one(4'd9);
        mem_valid = 1; mem_rd = 4'd8; mem_data = 16'h1111;
        alu_valid = 1; alu_rd = 4'd9; alu_data = 16'h2222;
        tick();
        alu_valid = 0;
        vectors++;
        if ({alu_ready, wb_write} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL areset_setup: rdy=%b wr=%b expected 0 1", alu_ready, wb_write);
        end
        #1;
        reset = 0;
        #1;
        vectors++;
        if ({wb_write, wb_rd, wb_data, busy, err, alu_ready} !==
            {1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL areset_immediate: wr=%b rd=%h data=%h busy=%h err=%b rdy=%b expected zeros, rdy=1",
                     wb_write, wb_rd, wb_data, busy, err, alu_ready);
        end
        idle_inputs();
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_random();
        logic [NUM_REG-1:0] m_busy;
        logic [REG_AW+DATA_W-1:0] m_skid[$];
        logic m_err, m_wr, exp_stall, exp_ready, alu_take, sv;
        logic [REG_AW-1:0] m_rd, srd;
        logic [DATA_W-1:0] m_data, sdat;
        logic [REG_AW+DATA_W-1:0] ent;
        apply_reset();
        m_busy = '0; m_skid.delete(); m_err = 0; m_wr = 0; m_rd = 0; m_data = 0;
        exp_ready = 1; exp_stall = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!(issue_valid && exp_stall)) begin
                issue_valid = ($urandom_range(0, 1) == 1);
                issue_wr    = ($urandom_range(0, 3) != 0);
                issue_rs1   = 4'($urandom_range(0, 15));
                issue_rs2   = 4'($urandom_range(0, 15));
                issue_rd    = 4'($urandom_range(0, 15));
            end
            if (!(alu_valid && !exp_ready)) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_rd    = pick_rd(m_busy);
                alu_data  = 16'($urandom);
            end
            mem_valid = ($urandom_range(0, 9) < 4);
            mem_rd    = pick_rd(m_busy);
            mem_data  = 16'($urandom);
            #1;
            exp_ready = (m_skid.size() == 0);
            exp_stall = issue_valid && ((issue_rs1 != 0 && m_busy[issue_rs1]) ||
                                        (issue_rs2 != 0 && m_busy[issue_rs2]) ||
                                        (issue_wr && issue_rd != 0 && m_busy[issue_rd]));
            vectors++;
            if ({stall, alu_ready} !== {exp_stall, exp_ready}) begin
                miscompares++;
                $display("FAIL rand_comb cyc%0d: stall=%b rdy=%b expected %b %b",
                         cyc, stall, alu_ready, exp_stall, exp_ready);
            end
            alu_take = alu_valid && exp_ready;
            sv = 0; srd = 0; sdat = 0;
            if (mem_valid) begin
                sv = 1; srd = mem_rd; sdat = mem_data;
                if (alu_take) m_skid.push_back({alu_rd, alu_data});
            end else if (m_skid.size() > 0) begin
                ent = m_skid.pop_front();
                sv = 1; srd = ent[REG_AW+DATA_W-1:DATA_W]; sdat = ent[DATA_W-1:0];
            end else if (alu_take) begin
                sv = 1; srd = alu_rd; sdat = alu_data;
            end
            m_wr = sv && (srd != 0);
            if (m_wr) begin
                m_rd = srd; m_data = sdat;
                if (!m_busy[srd]) m_err = 1;
                m_busy[srd] = 0;
            end
            if (issue_valid && !exp_stall && issue_wr && issue_rd != 0) m_busy[issue_rd] = 1;
            tick();
            vectors++;
            if ({wb_write, busy, err} !== {m_wr, m_busy, m_err} ||
                (m_wr && {wb_rd, wb_data} !== {m_rd, m_data})) begin
                miscompares++;
                $display("FAIL rand_wb cyc%0d: wr=%b rd=%0d data=%h busy=%h err=%b expected %b %0d %h %h %b",
                         cyc, wb_write, wb_rd, wb_data, busy, err, m_wr, m_rd, m_data, m_busy, m_err);
            end
        end
        idle_inputs();
    endtask

    function automatic logic [REG_AW-1:0] pick_rd(input logic [NUM_REG-1:0] b);
        logic [REG_AW-1:0] r;
        if (b != 0 && $urandom_range(0, 9) < 8) begin
            do r = 4'($urandom_range(0, 15)); while (!b[r]);
            return r;
        end
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        idle_inputs();
        reset = 1;
        #1;
        test_reset();
        test_basic_write();
        test_stall();
        test_collision();
        test_rd_zero();
        test_err();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
